// File: rtl/pred_update_sched.sv
// Branch predictor table port arbiter: interleaves prediction lookups with queued
// read-modify-write counter updates on a single-port 2-bit-counter table.
module pred_update_sched #(
   parameter int unsigned IDX_W        = 10,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             lookup_valid_i,
   input  logic [IDX_W-1:0] lookup_idx_i,
   output logic             lookup_ready_o,
   input  logic             upd_valid_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   output logic             upd_ready_o,
   output logic             pred_valid_o,
   output logic             pred_taken_o,
   output logic             tbl_en_o,
   output logic             tbl_we_o,
   output logic [IDX_W-1:0] tbl_idx_o,
   output logic [1:0]       tbl_wdata_o,
   input  logic [1:0]       tbl_rdata_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             taken;
   } entry_t;

   typedef enum logic {IDLE, UPD_WR} state_t;

   state_t           state_q, state_d;
   entry_t           fifo_q [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [STV_W-1:0] starve_q, starve_d;
   logic             pred_pend_q;
   logic             push, pop, fifo_empty, fifo_full;
   logic             upd_issue, lookup_acc;

   // Saturating 2-bit counter step, no wrap in either direction.
   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
      else       return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
   endfunction

   assign head        = fifo_q[rd_ptr_q];
   assign fifo_empty  = (count_q == '0);
   assign fifo_full   = (count_q == CNT_W'(DEPTH));
   assign upd_ready_o = !fifo_full;
   assign push        = upd_valid_i && !fifo_full;

   assign pred_valid_o = pred_pend_q;
   assign pred_taken_o = pred_pend_q & tbl_rdata_i[1];

   // Arbitration: pending updates win when idle port, near-full FIFO, or starved.
   always_comb begin
      state_d        = state_q;
      starve_d       = starve_q;
      lookup_ready_o = 1'b0;
      tbl_en_o       = 1'b0;
      tbl_we_o       = 1'b0;
      tbl_idx_o      = '0;
      tbl_wdata_o    = '0;
      pop            = 1'b0;
      upd_issue      = 1'b0;
      lookup_acc     = 1'b0;
      if (rst_ni) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty && (!lookup_valid_i || count_q >= CNT_W'(DEPTH - 1) ||
                                   starve_q == STV_W'(STARVE_LIMIT))) begin
                  upd_issue = 1'b1;
                  tbl_en_o  = 1'b1;
                  tbl_idx_o = head.idx;
                  state_d   = UPD_WR;
               end else if (lookup_valid_i) begin
                  lookup_acc     = 1'b1;
                  lookup_ready_o = 1'b1;
                  tbl_en_o       = 1'b1;
                  tbl_idx_o      = lookup_idx_i;
               end
            end
            UPD_WR: begin
               tbl_en_o    = 1'b1;
               tbl_we_o    = 1'b1;
               tbl_idx_o   = head.idx;
               tbl_wdata_o = sat_ctr(tbl_rdata_i, head.taken);
               pop         = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
         if (upd_issue || fifo_empty) begin
            starve_d = '0;
         end else if (lookup_acc && starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         pred_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         pred_pend_q <= lookup_acc;
      end
   end

   // FIFO bookkeeping; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= '{idx: upd_idx_i, taken: upd_taken_i};
   end

endmodule

// File: tb/tb_pred_update_sched.sv
// Scoreboard bench for pred_update_sched: expected table accesses and predictions
// are queued by directed stimulus and checked by a monitor against a table model.
module tb_pred_update_sched;

   typedef struct packed {
      logic       we;
      logic [9:0] idx;
      logic [1:0] wdata;
   } acc_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       lookup_valid, lookup_ready;
   logic [9:0] lookup_idx;
   logic       upd_valid, upd_ready, upd_taken;
   logic [9:0] upd_idx;
   logic       pred_valid, pred_taken;
   logic       tbl_en, tbl_we;
   logic [9:0] tbl_idx;
   logic [1:0] tbl_wdata, tbl_rdata;

   logic       pl_en;
   logic [9:0] pl_idx;
   logic [1:0] pl_val;
   logic [1:0] mem [1024];

   acc_t exp_acc [$];
   logic exp_pred [$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pred_update_sched #(.IDX_W(10), .DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_ready_o(lookup_ready),
      .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken),
      .upd_ready_o(upd_ready), .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
      .tbl_en_o(tbl_en), .tbl_we_o(tbl_we), .tbl_idx_o(tbl_idx),
      .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata)
   );

   // Single-port table model with one-cycle read latency and a preload port.
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_val;
      if (tbl_en) begin
         if (tbl_we) mem[tbl_idx] <= tbl_wdata;
         else        tbl_rdata    <= mem[tbl_idx];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] idx, input logic [1:0] val);
      tick();
      pl_en  = 1'b1;
      pl_idx = idx;
      pl_val = val;
      tick();
      pl_en  = 1'b0;
   endtask

   task automatic exp_push(input logic we, input logic [9:0] idx, input logic [1:0] wdata);
      acc_t e;
      e.we    = we;
      e.idx   = idx;
      e.wdata = wdata;
      exp_acc.push_back(e);
   endtask

   task automatic run_monitor();
      acc_t       e;
      logic       prev_rd  = 1'b0;
      logic [9:0] prev_idx = '0;
      forever begin
         @(negedge clk);
         if (tbl_en) begin
            if (exp_acc.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_access: got we=%0b idx=%0d, required no access", tbl_we, tbl_idx);
            end else begin
               e = exp_acc.pop_front();
               check("acc_we", 32'(tbl_we), 32'(e.we));
               check("acc_idx", 32'(tbl_idx), 32'(e.idx));
               if (e.we) check("acc_wdata", 32'(tbl_wdata), 32'(e.wdata));
            end
            if (tbl_we) check("wr_follows_rd", {21'd0, prev_rd, prev_idx}, {21'd0, 1'b1, tbl_idx});
         end else begin
            check("idle_idx", 32'(tbl_idx), 32'd0);
            check("idle_wdata", 32'(tbl_wdata), 32'd0);
         end
         if (pred_valid) begin
            if (exp_pred.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pred: got taken=%0b, required no prediction", pred_taken);
            end else begin
               check("pred_taken", 32'(pred_taken), 32'(exp_pred.pop_front()));
            end
         end else begin
            check("pred_idle", 32'(pred_taken), 32'd0);
         end
         prev_rd  = tbl_en && !tbl_we;
         prev_idx = tbl_idx;
      end
   endtask

   initial begin
      logic [15:0] rdy_fill;
      logic [13:0] rdy_starve;
      logic [5:0]  tk;
      int          k;

      rst_ni       = 1'b0;
      lookup_valid = 1'b1;
      lookup_idx   = 10'd7;
      upd_valid    = 1'b0;
      upd_idx      = '0;
      upd_taken    = 1'b0;
      pl_en        = 1'b0;
      pl_idx       = '0;
      pl_val       = '0;
      fork
         run_monitor();
      join_none

      // Reset state, with a lookup held to show it is not accepted in reset.
      repeat (2) @(negedge clk);
      check("rst_upd_ready", 32'(upd_ready), 32'd1);
      check("rst_tbl_en", 32'(tbl_en), 32'd0);
      check("rst_tbl_we", 32'(tbl_we), 32'd0);
      check("rst_pred_valid", 32'(pred_valid), 32'd0);
      check("rst_lookup_ready", 32'(lookup_ready), 32'd0);
      lookup_valid = 1'b0;
      tick();
      rst_ni = 1'b1;

      // Single update idx 5 taken on counter 1: read then write 2.
      preload(10'd5, 2'd1);
      exp_push(1'b0, 10'd5, 2'd0);
      exp_push(1'b1, 10'd5, 2'd2);
      tick();
      upd_valid = 1'b1; upd_idx = 10'd5; upd_taken = 1'b1;
      tick();
      upd_valid = 1'b0;
      repeat (4) tick();
      check("mem5_after", 32'(mem[5]), 32'd2);
      check("empty_upd_ready", 32'(upd_ready), 32'd1);

      // Saturation at both ends.
      preload(10'd9, 2'd3);
      preload(10'd11, 2'd0);
      exp_push(1'b0, 10'd9, 2'd0);
      exp_push(1'b1, 10'd9, 2'd3);
      exp_push(1'b0, 10'd11, 2'd0);
      exp_push(1'b1, 10'd11, 2'd0);
      tick();
      upd_valid = 1'b1; upd_idx = 10'd9; upd_taken = 1'b1;
      tick();
      upd_idx = 10'd11; upd_taken = 1'b0;
      tick();
      upd_valid = 1'b0;
      repeat (6) tick();
      check("mem9_sat_hi", 32'(mem[9]), 32'd3);
      check("mem11_sat_lo", 32'(mem[11]), 32'd0);

      // Plain lookups: counter 2 predicts taken, counter 1 not taken.
      preload(10'd7, 2'd2);
      preload(10'd8, 2'd1);
      exp_push(1'b0, 10'd7, 2'd0);
      exp_push(1'b0, 10'd8, 2'd0);
      exp_pred.push_back(1'b1);
      exp_pred.push_back(1'b0);
      tick();
      lookup_valid = 1'b1; lookup_idx = 10'd7;
      tick();
      lookup_idx = 10'd8;
      tick();
      lookup_valid = 1'b0;
      repeat (3) tick();

      // Starvation: one update to the looked-up index waits 8 accepted lookups;
      // lookups before the write see the old counter.
      preload(10'd20, 2'd1);
      for (int i = 0; i < 10; i++) exp_push(1'b0, 10'd20, 2'd0);
      exp_push(1'b1, 10'd20, 2'd2);
      for (int i = 0; i < 3; i++) exp_push(1'b0, 10'd20, 2'd0);
      for (int i = 0; i < 9; i++) exp_pred.push_back(1'b0);
      for (int i = 0; i < 3; i++) exp_pred.push_back(1'b1);
      rdy_starve = 14'b11_1001_1111_1111;
      for (int c = 0; c < 14; c++) begin
         tick();
         lookup_valid = 1'b1; lookup_idx = 10'd20;
         upd_valid = (c == 0); upd_idx = 10'd20; upd_taken = 1'b1;
         @(negedge clk);
         check("starve_lookup_ready", 32'(lookup_ready), 32'(rdy_starve[c[3:0]]));
      end
      tick();
      lookup_valid = 1'b0; upd_valid = 1'b0;
      repeat (3) tick();

      // FIFO fill under continuous lookups: updates forced at count 3.
      preload(10'd3, 2'd2);
      preload(10'd40, 2'd0);
      preload(10'd41, 2'd1);
      preload(10'd42, 2'd2);
      preload(10'd43, 2'd3);
      preload(10'd44, 2'd0);
      preload(10'd45, 2'd2);
      for (int i = 0; i < 3; i++) exp_push(1'b0, 10'd3, 2'd0);
      for (int i = 0; i < 3; i++) exp_pred.push_back(1'b1);
      exp_push(1'b0, 10'd40, 2'd0); exp_push(1'b1, 10'd40, 2'd1);
      exp_push(1'b0, 10'd41, 2'd0); exp_push(1'b1, 10'd41, 2'd0);
      exp_push(1'b0, 10'd42, 2'd0); exp_push(1'b1, 10'd42, 2'd3);
      exp_push(1'b0, 10'd43, 2'd0); exp_push(1'b1, 10'd43, 2'd3);
      exp_push(1'b0, 10'd44, 2'd0); exp_push(1'b1, 10'd44, 2'd0);
      exp_push(1'b0, 10'd45, 2'd0); exp_push(1'b1, 10'd45, 2'd1);
      tk       = 6'b001101;
      rdy_fill = 16'b1111_1110_1010_1111;
      k        = 0;
      for (int c = 0; c < 16; c++) begin
         tick();
         lookup_valid = (c <= 10); lookup_idx = 10'd3;
         upd_valid = (k < 6);
         upd_idx   = 10'(40 + k);
         upd_taken = (k < 6) ? tk[k[2:0]] : 1'b0;
         @(negedge clk);
         check("fill_upd_ready", 32'(upd_ready), 32'(rdy_fill[c[3:0]]));
         if (upd_valid && upd_ready) k++;
      end
      tick();
      lookup_valid = 1'b0; upd_valid = 1'b0;
      repeat (3) tick();
      check("fill_all_pushed", 32'(k), 32'd6);

      // Reset during the write cycle drops the write and empties the FIFO.
      preload(10'd50, 2'd1);
      exp_push(1'b0, 10'd50, 2'd0);
      tick();
      upd_valid = 1'b1; upd_idx = 10'd50; upd_taken = 1'b1;
      tick();
      upd_valid = 1'b0;
      tick();
      rst_ni = 1'b0;
      #1;
      check("rst_wr_tbl_we", 32'(tbl_we), 32'd0);
      check("rst_wr_tbl_en", 32'(tbl_en), 32'd0);
      check("rst_wr_upd_ready", 32'(upd_ready), 32'd1);
      repeat (2) tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      check("mem50_unwritten", 32'(mem[50]), 32'd1);
      exp_push(1'b0, 10'd50, 2'd0);
      exp_pred.push_back(1'b0);
      lookup_valid = 1'b1; lookup_idx = 10'd50;
      tick();
      lookup_valid = 1'b0;
      repeat (3) tick();

      check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
      check("pred_queue_drained", 32'(exp_pred.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pred_update_sched.md
PRED_UPDATE_SCHED -- requirements
Module: pred_update_sched

Interface
REQ-001 SHALL have parameter IDX_W, default 10, predictor table index width.
REQ-002 SHALL have parameter DEPTH, default 4, update FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, max cycles a pending update may wait.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named clk_i and rst_ni.
REQ-005 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port lookup_valid_i  input  1  prediction request.
REQ-008 SHALL have port lookup_idx_i  input  IDX_W  prediction index.
REQ-009 SHALL have port lookup_ready_o  output  1  lookup accepted this cycle when high with valid.
REQ-010 SHALL have port upd_valid_i  input  1  branch-resolution update offered.
REQ-011 SHALL have port upd_idx_i  input  IDX_W  update index.
REQ-012 SHALL have port upd_taken_i  input  1  resolved branch outcome.
REQ-013 SHALL have port upd_ready_o  output  1  FIFO can accept the update.
REQ-014 SHALL have port pred_valid_o  output  1  prediction valid (one cycle after lookup accept).
REQ-015 SHALL have port pred_taken_o  output  1  predicted direction.
REQ-016 SHALL have port tbl_en_o  output  1  single-port table access enable.
REQ-017 SHALL have port tbl_we_o  output  1  table write enable.
REQ-018 SHALL have port tbl_idx_o  output  IDX_W  table address.
REQ-019 SHALL have port tbl_wdata_o  output  2  2-bit counter write data.
REQ-020 SHALL have port tbl_rdata_i  input  2  table read data, valid one cycle after read with en=1, we=0.

Function
REQ-021 SHALL push {upd_idx_i, upd_taken_i} into FIFO when upd_valid_i && upd_ready_o; upd_ready_o = FIFO not full (no push-through when full, even if popping).
REQ-022 SHALL use FSM states IDLE and UPD_WR; one table access per cycle maximum.
REQ-023 SHALL in IDLE start an update (tbl_en_o=1, tbl_we_o=0, tbl_idx_o=FIFO head idx, go UPD_WR) when FIFO non-empty and (lookup_valid_i=0, or count >= DEPTH-1, or starve counter == STARVE_LIMIT).
REQ-024 SHALL otherwise in IDLE accept a valid lookup: lookup_ready_o=1, tbl_en_o=1, tbl_we_o=0, tbl_idx_o=lookup_idx_i.
REQ-025 SHALL drive lookup_ready_o=0 whenever an update read is issued or state is UPD_WR.
REQ-026 SHALL in UPD_WR drive tbl_en_o=1, tbl_we_o=1, tbl_idx_o=head idx, tbl_wdata_o=sat(tbl_rdata_i, head taken), pop FIFO, return to IDLE.
REQ-027 SHALL compute sat as: taken -> min(ctr+1, 3); not taken -> max(ctr-1, 0); 2-bit unsigned, no wrap.
REQ-028 SHALL assert pred_valid_o exactly one cycle after lookup acceptance, with pred_taken_o = tbl_rdata_i[1] in that cycle; otherwise pred_valid_o=0, pred_taken_o=0.
REQ-029 SHALL increment starve counter each IDLE cycle a lookup is accepted while FIFO non-empty, saturating at STARVE_LIMIT; clear it when an update read issues or FIFO is empty.
REQ-030 SHALL return pre-update table contents for a lookup hitting an index with a pending FIFO update (no forwarding).
REQ-031 SHALL handle push and pop in the same cycle with count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-032 SHALL drive tbl_wdata_o=0 and tbl_idx_o=0 when tbl_en_o=0.

Reset
REQ-033 SHALL on rst_ni low asynchronously clear FIFO (count 0), state to IDLE, starve counter 0, pred_valid_o, pred_taken_o, tbl_en_o, tbl_we_o to 0; upd_ready_o=1 after reset.
REQ-034 SHALL discard any in-flight update (no write) when reset asserts in UPD_WR.

Verification
REQ-035 SHALL test: single update idx=5 taken, table holds 1, no lookups -> read idx 5 cycle N, write 2 cycle N+1, FIFO empty.
REQ-036 SHALL test: counter 3 + taken -> writes 3; counter 0 + not taken -> writes 0.
REQ-037 SHALL test: continuous lookups, one pending update, count < DEPTH-1 -> update issues after exactly 8 accepted lookups.
REQ-038 SHALL test: fill DEPTH=4 FIFO while lookups continuous -> updates forced at count 3; upd_ready_o=0 only at count 4.
REQ-039 SHALL test: lookup idx=7, table holds 2 -> pred_valid_o=1, pred_taken_o=1 next cycle.
REQ-040 SHALL test: rst_ni low during UPD_WR -> tbl_we_o=0 immediately, count 0, state IDLE.
